// File: rtl/memory_bus_arbiter.sv
// Round-robin arbiter sharing one downstream MemoryBus slave among NUM_MASTERS
// requesters; responses are routed back by smID and outstanding reads are capped.

module memory_bus_arbiter_port (
  input  logic i_ms_valid,
  input  logic i_ms_write,
  input  logic i_room,
  input  logic i_sm_hit,
  input  logic i_sm_valid,
  output logic o_elig,
  output logic o_sm_valid
);
  // Writes never consume a read slot, so they stay eligible at the cap.
  assign o_elig     = i_ms_valid & (i_ms_write | i_room);
  assign o_sm_valid = i_sm_hit & i_sm_valid;
endmodule

module memory_bus_arbiter #(
  parameter int NUM_MASTERS     = 4,
  parameter int DATA_WIDTH      = 24,
  parameter int ADDRESS_WIDTH   = 32,
  parameter int ID_WIDTH        = 4,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                                        clock,
  input  logic                                        reset,
  input  logic [NUM_MASTERS-1:0]                      up_msValid,
  output logic [NUM_MASTERS-1:0]                      up_msReady,
  input  logic [NUM_MASTERS-1:0][ADDRESS_WIDTH-1:0]   up_msAddress,
  input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]      up_msData,
  input  logic [NUM_MASTERS-1:0]                      up_msWrite,
  output logic [NUM_MASTERS-1:0]                      up_smValid,
  input  logic [NUM_MASTERS-1:0]                      up_smReady,
  output logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]      up_smData,
  output logic                                        dn_msValid,
  output logic [ADDRESS_WIDTH-1:0]                    dn_msAddress,
  output logic [DATA_WIDTH-1:0]                       dn_msData,
  output logic                                        dn_msWrite,
  output logic [ID_WIDTH-1:0]                         dn_msID,
  input  logic                                        dn_msReady,
  input  logic                                        dn_smValid,
  input  logic [DATA_WIDTH-1:0]                       dn_smData,
  input  logic [ID_WIDTH-1:0]                         dn_smID,
  output logic                                        dn_smReady,
  output logic [7:0]                                  outstanding,
  output logic                                        idError
);
  localparam int                GW     = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam logic [7:0]        MAX_OS = 8'(MAX_OUTSTANDING);
  localparam logic [ID_WIDTH:0] NM     = (ID_WIDTH+1)'(NUM_MASTERS);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t                 r_state, w_state_nxt;
  logic [GW-1:0]          r_grant, r_last, w_pick, w_cand, w_sm_idx;
  logic [7:0]             r_outstanding;
  logic                   r_id_err;
  logic                   w_found, w_room, w_sm_known, w_req_hs, w_inc, w_dec;
  logic [NUM_MASTERS-1:0] w_elig;

  assign w_room     = r_outstanding < MAX_OS;
  assign w_sm_known = {1'b0, dn_smID} < NM;
  assign w_sm_idx   = dn_smID[GW-1:0];

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_port
    memory_bus_arbiter_port u_port (
      .i_ms_valid (up_msValid[i]),
      .i_ms_write (up_msWrite[i]),
      .i_room     (w_room),
      .i_sm_hit   (w_sm_known && (w_sm_idx == GW'(i))),
      .i_sm_valid (dn_smValid),
      .o_elig     (w_elig[i]),
      .o_sm_valid (up_smValid[i])
    );
    assign up_smData[i] = dn_smData;
  end

  // Search starts one past the last winner and wraps.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_last;
    w_cand  = r_last;
    for (int off = 1; off <= NUM_MASTERS; off++) begin
      w_cand = GW'((int'(r_last) + off) % NUM_MASTERS);
      if (!w_found && w_elig[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    dn_msValid  = 1'b0;
    up_msReady  = '0;
    case (r_state)
      S_IDLE:  if (w_found) w_state_nxt = S_GRANT;
      S_GRANT: begin
        dn_msValid          = up_msValid[r_grant];
        up_msReady[r_grant] = dn_msReady;
        if (dn_msValid && dn_msReady) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign dn_msAddress = up_msAddress[r_grant];
  assign dn_msData    = up_msData[r_grant];
  assign dn_msWrite   = up_msWrite[r_grant];
  assign dn_msID      = ID_WIDTH'(r_grant);

  // Unknown IDs are drained so a bad slave cannot wedge the response channel.
  assign dn_smReady = w_sm_known ? up_smReady[w_sm_idx] : 1'b1;

  assign w_req_hs = dn_msValid & dn_msReady;
  assign w_inc    = w_req_hs & ~dn_msWrite;
  assign w_dec    = dn_smValid & dn_smReady & w_sm_known & (r_outstanding != 8'd0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_grant       <= '0;
      r_last        <= GW'(NUM_MASTERS - 1);
      r_outstanding <= '0;
      r_id_err      <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_found) r_grant <= w_pick;
      if (w_req_hs) r_last <= r_grant;
      if (w_inc && !w_dec)      r_outstanding <= r_outstanding + 8'd1;
      else if (w_dec && !w_inc) r_outstanding <= r_outstanding - 8'd1;
      if (dn_smValid && !w_sm_known) r_id_err <= 1'b1;
    end
  end

  assign outstanding = r_outstanding;
  assign idError     = r_id_err;
endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Scoreboard bench for memory_bus_arbiter: expected downstream requests and
// upstream responses are queued by the stimulus and popped by a monitor.

module tb_memory_bus_arbiter;
  localparam int NM = 4, DW = 24, AW = 32, IW = 4, MO = 2;

  logic                   clock = 1'b0, reset = 1'b0;
  logic [NM-1:0]          up_msValid = '0, up_msReady, up_msWrite = '0;
  logic [NM-1:0][AW-1:0]  up_msAddress = '0;
  logic [NM-1:0][DW-1:0]  up_msData = '0, up_smData;
  logic [NM-1:0]          up_smValid, up_smReady = '0;
  logic                   dn_msValid, dn_msWrite, dn_msReady = 1'b0;
  logic [AW-1:0]          dn_msAddress;
  logic [DW-1:0]          dn_msData, dn_smData = '0;
  logic [IW-1:0]          dn_msID, dn_smID = '0;
  logic                   dn_smValid = 1'b0, dn_smReady, idError;
  logic [7:0]             outstanding;

  memory_bus_arbiter #(.NUM_MASTERS(NM), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW),
                       .ID_WIDTH(IW), .MAX_OUTSTANDING(MO)) dut (
    .clock(clock), .reset(reset),
    .up_msValid(up_msValid), .up_msReady(up_msReady), .up_msAddress(up_msAddress),
    .up_msData(up_msData), .up_msWrite(up_msWrite),
    .up_smValid(up_smValid), .up_smReady(up_smReady), .up_smData(up_smData),
    .dn_msValid(dn_msValid), .dn_msAddress(dn_msAddress), .dn_msData(dn_msData),
    .dn_msWrite(dn_msWrite), .dn_msID(dn_msID), .dn_msReady(dn_msReady),
    .dn_smValid(dn_smValid), .dn_smData(dn_smData), .dn_smID(dn_smID),
    .dn_smReady(dn_smReady), .outstanding(outstanding), .idError(idError)
  );

  initial forever #5 clock = ~clock;

  typedef struct { logic [IW-1:0] id; logic [AW-1:0] addr; logic [DW-1:0] data; logic wr; } req_t;
  typedef struct { int port; logic [DW-1:0] data; } rsp_t;
  req_t exp_req[$];
  rsp_t exp_rsp[$];
  int   checks = 0, errors = 0;
  int   cyc = 0, prev_cyc = 0;
  bit   rate_on = 0, have_prev = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock); #1;
  endtask

  function automatic void push_req(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic wr);
    req_t r;
    r.id = IW'(p); r.addr = a; r.data = d; r.wr = wr;
    exp_req.push_back(r);
  endfunction

  function automatic void push_rsp(input int p, input logic [DW-1:0] d);
    rsp_t r;
    r.port = p; r.data = d;
    exp_rsp.push_back(r);
  endfunction

  task automatic issue(input int p, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit done = 0;
    up_msWrite[p] = wr; up_msAddress[p] = a; up_msData[p] = d; up_msValid[p] = 1'b1;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clock);
      if (up_msReady[p]) begin
        @(posedge clock); #1;
        done = 1;
      end
    end
    up_msValid[p] = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL issue_timeout: port %0d never granted, expected grant", p);
    end
  endtask

  task automatic respond(input int k, input logic [DW-1:0] d);
    dn_smValid = 1'b1; dn_smID = IW'(k); dn_smData = d;
    step();
    dn_smValid = 1'b0;
  endtask

  // Monitor: every downstream handshake and upstream response is checked
  // against the head of its expectation queue.
  initial begin
    req_t r;
    rsp_t s;
    forever begin
      @(negedge clock);
      cyc++;
      if (reset) begin
        if (dn_msValid && dn_msReady) begin
          if (exp_req.size() == 0) begin
            checks++; errors++;
            $display("FAIL req_unexpected: id %0d addr %0h, expected no request", dn_msID, dn_msAddress);
          end else begin
            r = exp_req.pop_front();
            chk("req", {dn_msID, dn_msAddress, dn_msData, dn_msWrite}, {r.id, r.addr, r.data, r.wr});
          end
          if (rate_on) begin
            if (have_prev) chk("req_rate", 128'(cyc - prev_cyc), 128'd2);
            prev_cyc = cyc; have_prev = 1;
          end
        end
        for (int i = 0; i < NM; i++) begin
          if (up_smValid[i] && up_smReady[i]) begin
            if (exp_rsp.size() == 0) begin
              checks++; errors++;
              $display("FAIL rsp_unexpected: port %0d data %0h, expected no response", i, up_smData[i]);
            end else begin
              s = exp_rsp.pop_front();
              chk("rsp", {32'(i), up_smData[i]}, {32'(s.port), s.data});
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset values
    #1;
    chk("rst_dn_msValid", dn_msValid, 0);
    chk("rst_up_msReady", up_msReady, 0);
    chk("rst_up_smValid", up_smValid, 0);
    chk("rst_dn_smReady", dn_smReady, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_idError", idError, 0);
    #11 reset = 1'b1;
    up_smReady = '1; dn_msReady = 1'b1;
    step();

    // single read from port 2, then its response
    push_req(2, 32'h100, 24'h0, 1'b0);
    up_msWrite[2] = 1'b0; up_msAddress[2] = 32'h100; up_msData[2] = '0; up_msValid[2] = 1'b1;
    #1 chk("t1_no_valid_same_cycle", dn_msValid, 0);
    step();
    chk("t1_dn_msValid", dn_msValid, 1);
    chk("t1_dn_msID", dn_msID, 2);
    chk("t1_outstanding_before", outstanding, 0);
    step();
    up_msValid[2] = 1'b0;
    chk("t1_outstanding_after", outstanding, 1);
    push_rsp(2, 24'hABCDEF);
    dn_smValid = 1'b1; dn_smID = 4'd2; dn_smData = 24'hABCDEF;
    #1 chk("t1_up_smValid", up_smValid, 4'b0100);
    chk("t1_dn_smReady", dn_smReady, 1);
    step();
    dn_smValid = 1'b0;
    chk("t1_outstanding_done", outstanding, 0);

    // fresh reset, then all four ports stream writes
    @(negedge clock); reset = 1'b0; #2 reset = 1'b1;
    step();
    push_req(0, 32'h200, 24'h10, 1'b1);
    push_req(1, 32'h210, 24'h11, 1'b1);
    push_req(2, 32'h220, 24'h12, 1'b1);
    push_req(3, 32'h230, 24'h13, 1'b1);
    push_req(0, 32'h204, 24'h14, 1'b1);
    have_prev = 0; rate_on = 1;
    fork
      begin issue(0, 1'b1, 32'h200, 24'h10); issue(0, 1'b1, 32'h204, 24'h14); end
      issue(1, 1'b1, 32'h210, 24'h11);
      issue(2, 1'b1, 32'h220, 24'h12);
      issue(3, 1'b1, 32'h230, 24'h13);
    join
    rate_on = 0;
    chk("t2_outstanding", outstanding, 0);

    // read cap at MAX_OUTSTANDING = 2
    push_req(0, 32'h300, 24'h0, 1'b0);
    push_req(0, 32'h304, 24'h0, 1'b0);
    issue(0, 1'b0, 32'h300, 24'h0);
    issue(0, 1'b0, 32'h304, 24'h0);
    chk("t3_outstanding_full", outstanding, 2);
    push_req(1, 32'h310, 24'h55, 1'b1);
    push_req(0, 32'h308, 24'h0, 1'b0);
    push_rsp(0, 24'h000111);
    fork
      issue(0, 1'b0, 32'h308, 24'h0);
      begin
        repeat (3) step();
        chk("t3_third_blocked", dn_msValid, 0);
        chk("t3_third_not_ready", up_msReady[0], 0);
        issue(1, 1'b1, 32'h310, 24'h55);
        chk("t3_outstanding_after_wr", outstanding, 2);
        respond(0, 24'h000111);
      end
    join
    chk("t3_outstanding_third", outstanding, 2);
    push_rsp(0, 24'h000222);
    respond(0, 24'h000222);
    chk("t3_outstanding_one", outstanding, 1);

    // read accept and response in the same cycle
    push_req(2, 32'h400, 24'h0, 1'b0);
    push_rsp(3, 24'h333333);
    up_msWrite[2] = 1'b0; up_msAddress[2] = 32'h400; up_msData[2] = '0; up_msValid[2] = 1'b1;
    step();
    dn_smValid = 1'b1; dn_smID = 4'd3; dn_smData = 24'h333333;
    step();
    up_msValid[2] = 1'b0; dn_smValid = 1'b0;
    chk("t4_outstanding_same", outstanding, 1);

    // unknown response ID
    up_smReady = '0;
    dn_smValid = 1'b1; dn_smID = 4'd7; dn_smData = 24'hDEAD01;
    #1 chk("t5_dn_smReady", dn_smReady, 1);
    chk("t5_up_smValid", up_smValid, 0);
    step();
    dn_smValid = 1'b0;
    chk("t5_idError", idError, 1);
    chk("t5_outstanding", outstanding, 1);
    repeat (3) step();
    chk("t5_idError_sticky", idError, 1);
    up_smReady = '1;

    // drain, then a spurious response at zero
    push_rsp(1, 24'h111111);
    respond(1, 24'h111111);
    chk("t6_outstanding_zero", outstanding, 0);
    push_rsp(2, 24'h222222);
    respond(2, 24'h222222);
    chk("t6_no_underflow", outstanding, 0);

    // reset while granted with downstream stalled
    dn_msReady = 1'b0;
    up_msWrite[3] = 1'b1; up_msAddress[3] = 32'h500; up_msData[3] = 24'h77; up_msValid[3] = 1'b1;
    step(); step();
    chk("t7_granted", dn_msValid, 1);
    #2 reset = 1'b0;
    #1 chk("t7_async_drop", dn_msValid, 0);
    chk("t7_up_msReady", up_msReady, 0);
    chk("t7_outstanding", outstanding, 0);
    chk("t7_idError_cleared", idError, 0);
    #3 reset = 1'b1;
    dn_msReady = 1'b1;
    push_req(0, 32'h600, 24'h66, 1'b1);
    push_req(3, 32'h500, 24'h77, 1'b1);
    fork
      issue(0, 1'b1, 32'h600, 24'h66);
      issue(3, 1'b1, 32'h500, 24'h77);
    join
    step();

    chk("req_queue_empty", 128'(exp_req.size()), 0);
    chk("rsp_queue_empty", 128'(exp_rsp.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/memory_bus_arbiter.md
# memory_bus_arbiter

Shares one downstream MemoryBus slave port among `NUM_MASTERS` upstream requesters, such as several ray memory units, the pixel writer and the octree loader. It round-robins the request channel and rewrites `msID` to the winning port index. Responses are routed back by `smID`, and the block caps the number of outstanding reads. It sits between the ray cores and the memory controller.

## Interface
Parameters:
- `NUM_MASTERS`, 4: number of upstream ports, 2..16.
- `DATA_WIDTH`, 24: bus data width.
- `ADDRESS_WIDTH`, 32: bus address width.
- `ID_WIDTH`, 4: width of `msID`/`smID`; must satisfy 2^ID_WIDTH >= NUM_MASTERS.
- `MAX_OUTSTANDING`, 8: maximum reads accepted downstream and not yet answered, 1..255.

Ports (upstream ports are arrays `[NUM_MASTERS-1:0]`, index i = port i):
- `clock` in 1: single clock; all logic on posedge.
- `reset` in 1: asynchronous, active-low reset.
- `up_msValid` in 1 each: request valid from master i.
- `up_msReady` out 1 each: request accepted from master i.
- `up_msAddress` in ADDRESS_WIDTH each: request address.
- `up_msData` in DATA_WIDTH each: write data.
- `up_msWrite` in 1 each: 1 = write, 0 = read.
- `up_smValid` out 1 each: response valid to master i.
- `up_smReady` in 1 each: master i accepts response.
- `up_smData` out DATA_WIDTH each: response data; a copy of `dn_smData`.
- `dn_msValid`, `dn_msAddress`, `dn_msData`, `dn_msWrite`: out; granted request.
- `dn_msID` out ID_WIDTH: index of the granted port.
- `dn_msReady` in 1: downstream accepts request.
- `dn_smValid`, `dn_smData`, `dn_smID`: in; downstream response.
- `dn_smReady` out 1: response accepted.
- `outstanding` out 8: current count of outstanding reads.
- `idError` out 1: sticky; set when a response carries `smID >= NUM_MASTERS`.

## Operation
State machine:
- IDLE (no grant):
  - A port is eligible when its `up_msValid` = 1, and either it is a write, or it is a read and `outstanding < MAX_OUTSTANDING`.
  - If any port is eligible, grant the first eligible port searching from `last+1` upward, wrapping modulo NUM_MASTERS, and go to GRANTED.
- GRANTED(g):
  - `dn_ms*` = port g's request, combinational from the registered grant.
  - `dn_msID` = g.
  - `up_msReady[g]` = `dn_msReady`; `up_msReady` = 0 for all other ports.
  - On `dn_msValid & dn_msReady`: set `last` <= g and return to IDLE. If the request was a read, increment `outstanding`.
  - The grant is held until the handshake, even if the master drops `up_msValid` (protocol violation); in that case `dn_msValid` follows the master.
- Response path, combinational, no state:
  - With k = `dn_smID`: `up_smValid[k]` = `dn_smValid`, `dn_smReady` = `up_smReady[k]`; all other `up_smValid` = 0.
  - On a `dn_smValid & dn_smReady` handshake, decrement `outstanding`.
- Simultaneous read acceptance and response in the same cycle: `outstanding` is unchanged.
- `outstanding` never wraps:
  - An increment at MAX_OUTSTANDING cannot occur, because eligibility blocks it.
  - A decrement at 0 (spurious response) is ignored.
- Unknown ID (`dn_smID >= NUM_MASTERS`): drive `dn_smReady` = 1 to drain the response, set `idError`, and leave `outstanding` unchanged.
- Write data is passed straight through, with no width conversion. `up_smData` is a broadcast copy of `dn_smData` to every port.

## Timing
- Reset (`reset` = 0, async) values: state IDLE, `last` = NUM_MASTERS-1 (so port 0 wins first), `outstanding` = 0, `idError` = 0, all `up_msReady`/`up_smValid`/`dn_msValid`/`dn_smReady` = 0.
- Reset during GRANTED abandons the grant immediately. The downstream side must be reset concurrently.
- Request latency: master asserts valid in cycle t (while IDLE) -> `dn_msValid` in cycle t+1.
  - The earliest handshake is cycle t+1.
  - There is one idle bubble cycle between consecutive grants; sustained throughput is at most 1 request per 2 cycles.
- Response latency: 0 cycles, purely combinational. There are no response-path registers.
- Upstream masters must hold request fields stable while `up_msValid` = 1 and `up_msReady` = 0.

## Test plan
- Single port 2 read of address 0x100:
  - `dn_msValid` rises 1 cycle later with `dn_msID` = 2; `outstanding` goes 0->1.
  - Response with `smID` = 2, data 0xABCDEF reaches `up_smValid[2]` only; `outstanding` returns to 0.
- All 4 ports request writes continuously with `dn_msReady` = 1: grants go in order 0,1,2,3,0, one every 2 cycles; `outstanding` stays 0.
- MAX_OUTSTANDING = 2, three reads from port 0 with no responses:
  - The third read is not granted and `outstanding` = 2.
  - A write from port 1 is still granted.
  - After one response, the third read is granted.
- Response with `dn_smID` = 7 (NUM_MASTERS = 4): `dn_smReady` = 1, `idError` = 1 and stays 1, no `up_smValid` asserted.
- Read accepted and response completed in the same cycle with `outstanding` = 1: `outstanding` stays 1.
- Reset asserted while GRANTED with `dn_msReady` = 0: `dn_msValid` drops asynchronously. After release, port 0 wins the first grant.
